// File: rtl/apb_cfg_master_pkg.sv
// Shared definitions for the APB cfg master: FSM state encoding and the
// cfg register map that command sources use when talking to the accelerator.
package apb_cfg_master_pkg;

   // Master sequencing states
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SETUP     = 3'd1,
      ST_ACCESS    = 3'd2,
      ST_POLL_WAIT = 3'd3,
      ST_RESP      = 3'd4
   } apb_state_e;

   // cfg register map (byte addresses on the 8-bit APB address bus)
   localparam logic [7:0] CFG_ADDR_STATUS     = 8'h00;
   localparam logic [7:0] CFG_ADDR_START      = 8'h04;
   localparam logic [7:0] CFG_ADDR_MEAN       = 8'h08;
   localparam logic [7:0] CFG_ADDR_INV_VAR    = 8'h0C;
   localparam logic [7:0] CFG_ADDR_VALID_MASK = 8'h10;
   localparam logic [7:0] CFG_ADDR_MATRIX     = 8'h20;

   // done_tpu lives in bit 0 of the status register
   localparam logic [31:0] CFG_STATUS_DONE_TPU = 32'h0000_0001;

endpackage

// File: rtl/apb_cfg_master_timeout_ctr.sv
// Loadable down-counter with a zero flag; shared by the PREADY timeout and
// the idle gap between poll reads, which never run at the same time.
module apb_timeout_ctr
   import apb_cfg_master_pkg::*;
#(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Load has priority; decrement saturates at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/apb_cfg_master.sv
// APB initiator turning a host command stream into single writes, single
// reads and poll-until-match reads against the cfg register slave.
module apb_cfg_master
   import apb_cfg_master_pkg::*;
#(
   parameter int ADDR_W        = 8,
   parameter int DATA_W        = 32,
   parameter int READY_TIMEOUT = 16,
   parameter int POLL_GAP      = 4,
   parameter int POLL_MAX      = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic              cmd_poll,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic [DATA_W-1:0] cmd_mask,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_error,
   output logic [ADDR_W-1:0] PADDR,
   output logic              PWRITE,
   output logic              PSEL,
   output logic              PENABLE,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY
);

   localparam int CTR_MAX = (READY_TIMEOUT > POLL_GAP) ? READY_TIMEOUT : POLL_GAP;
   localparam int CTR_W   = $clog2(CTR_MAX + 1);

   apb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic              pwrite_q, pwrite_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] mask_q, mask_d;
   logic              poll_q, poll_d;
   logic [7:0]        poll_cnt_q, poll_cnt_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_error_q, rsp_error_d;

   logic              ctr_load;
   logic              ctr_dec;
   logic [CTR_W-1:0]  ctr_val;
   logic              ctr_zero;
   logic [7:0]        poll_cnt_nxt;
   logic              poll_match;

   // The expected value is kept apart from PWDATA because reads drive PWDATA=0
   assign poll_cnt_nxt = poll_cnt_q + 8'd1;
   assign poll_match   = (((PRDATA ^ wdata_q) & mask_q) == '0);

   apb_timeout_ctr #(.W(CTR_W)) u_ctr (
      .clk      (clk),
      .reset    (reset),
      .load     (ctr_load),
      .dec      (ctr_dec),
      .load_val (ctr_val),
      .zero     (ctr_zero)
   );

   // Next-state and next-output logic; every output is a flop so it is set one state early
   always_comb begin
      state_d     = state_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwdata_d    = pwdata_q;
      wdata_d     = wdata_q;
      mask_d      = mask_q;
      poll_d      = poll_q;
      poll_cnt_d  = poll_cnt_q;
      cmd_ready_d = cmd_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_error_d = rsp_error_q;
      ctr_load    = 1'b0;
      ctr_dec     = 1'b0;
      ctr_val     = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               paddr_d     = cmd_addr;
               pwrite_d    = cmd_write;
               pwdata_d    = cmd_write ? cmd_wdata : '0;
               wdata_d     = cmd_wdata;
               mask_d      = cmd_mask;
               poll_d      = cmd_poll && !cmd_write;
               poll_cnt_d  = '0;
               cmd_ready_d = 1'b0;
               rsp_rdata_d = '0;
               rsp_error_d = 1'b0;
               psel_d      = 1'b1;
               state_d     = ST_SETUP;
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
            ctr_load  = 1'b1;
            ctr_val   = CTR_W'(READY_TIMEOUT - 1);
            state_d   = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (PREADY) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               if (!pwrite_q) begin
                  rsp_rdata_d = PRDATA;
               end
               if (poll_q && !poll_match) begin
                  poll_cnt_d = poll_cnt_nxt;
                  if (poll_cnt_nxt == 8'(POLL_MAX)) begin
                     rsp_error_d = 1'b1;
                     rsp_valid_d = 1'b1;
                     state_d     = ST_RESP;
                  end else begin
                     ctr_load = 1'b1;
                     ctr_val  = CTR_W'(POLL_GAP - 1);
                     state_d  = ST_POLL_WAIT;
                  end
               end else begin
                  poll_cnt_d  = poll_q ? poll_cnt_nxt : poll_cnt_q;
                  rsp_valid_d = 1'b1;
                  state_d     = ST_RESP;
               end
            end else if (ctr_zero) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_error_d = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end else begin
               ctr_dec = 1'b1;
            end
         end
         ST_POLL_WAIT: begin
            if (ctr_zero) begin
               psel_d  = 1'b1;
               state_d = ST_SETUP;
            end else begin
               ctr_dec = 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops the bus immediately and discards the command
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwdata_q    <= '0;
         wdata_q     <= '0;
         mask_q      <= '0;
         poll_q      <= 1'b0;
         poll_cnt_q  <= '0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwdata_q    <= pwdata_d;
         wdata_q     <= wdata_d;
         mask_q      <= mask_d;
         poll_q      <= poll_d;
         poll_cnt_q  <= poll_cnt_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_error_q <= rsp_error_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_error = rsp_error_q;
   assign PADDR     = paddr_q;
   assign PWRITE    = pwrite_q;
   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_cfg_master.sv
// Directed bench for apb_cfg_master with a small programmable APB slave and
// a bus monitor that counts phases and flags protocol violations.
module tb_apb_cfg_master;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic        cmd_poll;
   logic [7:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic [31:0] cmd_mask;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   logic [7:0]  PADDR;
   logic        PWRITE;
   logic        PSEL;
   logic        PENABLE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;

   int checks = 0;
   int errors = 0;

   // Slave behaviour knobs: wait states per ACCESS (-1 = never ready) and read data
   int          slave_wait = 0;
   int          match_at   = 1;
   logic [31:0] match_data = '0;
   logic [31:0] miss_data  = '0;
   int          acc_cnt;
   int          rd_cnt;

   // Bus monitor results
   int          setup_cnt;
   int          access_cnt;
   int          gap_run;
   int          gap_min;
   int          gap_max;
   int          proto_viol = 0;
   logic        prev_setup;
   logic        prev_bus;
   logic [7:0]  prev_paddr;
   logic [31:0] prev_pwdata;
   logic        prev_pwrite;

   apb_cfg_master #(
      .ADDR_W        (8),
      .DATA_W        (32),
      .READY_TIMEOUT (16),
      .POLL_GAP      (4),
      .POLL_MAX      (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_poll  (cmd_poll),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .cmd_mask  (cmd_mask),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_error (rsp_error),
      .PADDR     (PADDR),
      .PWRITE    (PWRITE),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWDATA    (PWDATA),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave: PREADY after slave_wait low ACCESS cycles; data switches to match_data on read number match_at
   assign PREADY = (slave_wait >= 0) && (acc_cnt >= slave_wait);
   assign PRDATA = ((rd_cnt + 1) >= match_at) ? match_data : miss_data;

   // Slave wait-state and completed-read counters
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_cnt <= 0;
         rd_cnt  <= 0;
      end else begin
         acc_cnt <= (PSEL && PENABLE && !PREADY) ? acc_cnt + 1 : 0;
         if (cmd_valid && cmd_ready) begin
            rd_cnt <= 0;
         end else if (PSEL && PENABLE && PREADY && !PWRITE) begin
            rd_cnt <= rd_cnt + 1;
         end
      end
   end

   // Monitor: APB phase counting, idle gaps between transfers, protocol rules
   always @(negedge clk) begin
      if (reset) begin
         prev_setup <= 1'b0;
         prev_bus   <= 1'b0;
      end else begin
         if (PENABLE && !PSEL) proto_viol <= proto_viol + 1;
         if (prev_setup && !(PSEL && PENABLE)) proto_viol <= proto_viol + 1;
         if (PSEL && PENABLE && !prev_bus) proto_viol <= proto_viol + 1;
         if (PSEL && PENABLE && prev_bus &&
             (PADDR !== prev_paddr || PWDATA !== prev_pwdata || PWRITE !== prev_pwrite))
            proto_viol <= proto_viol + 1;
         prev_setup  <= PSEL && !PENABLE;
         prev_bus    <= PSEL;
         prev_paddr  <= PADDR;
         prev_pwdata <= PWDATA;
         prev_pwrite <= PWRITE;
      end
      if (reset || cmd_ready) begin
         setup_cnt  <= 0;
         access_cnt <= 0;
         gap_run    <= 0;
         gap_min    <= 999;
         gap_max    <= 0;
      end else begin
         if (PSEL && !PENABLE) begin
            setup_cnt <= setup_cnt + 1;
            gap_run   <= 0;
            if (gap_run > 0) begin
               gap_min <= (gap_run < gap_min) ? gap_run : gap_min;
               gap_max <= (gap_run > gap_max) ? gap_run : gap_max;
            end
         end
         if (PSEL && PENABLE) access_cnt <= access_cnt + 1;
         if (!PSEL) gap_run <= gap_run + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Present one command at a negedge, let the DUT accept it, return at the negedge after acceptance
   task automatic applyStimulus(input logic wr, input logic poll, input logic [7:0] addr,
                                input logic [31:0] wdata, input logic [31:0] mask);
      checkOutput("accept_ready", cmd_ready, 1'b1);
      cmd_write = wr;
      cmd_poll  = poll;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      cmd_mask  = mask;
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Count cycles since acceptance until rsp_valid, bounded
   task automatic waitResp(output int n);
      n = 1;
      while (rsp_valid !== 1'b1 && n < 80) begin
         @(negedge clk);
         n++;
      end
      #1;
   endtask

   task automatic finishResp(input string tag);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checkOutput({tag, "_rsp_cleared"}, rsp_valid, 1'b0);
      checkOutput({tag, "_cmd_ready"}, cmd_ready, 1'b1);
   endtask

   initial begin
      int   n;
      logic ok;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_poll  = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_mask  = '0;
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] reset state");
      checkOutput("rst_psel", PSEL, 1'b0);
      checkOutput("rst_penable", PENABLE, 1'b0);
      checkOutput("rst_cmd_ready", cmd_ready, 1'b1);
      checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
      checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
      checkOutput("rst_rsp_error", rsp_error, 1'b0);
      checkOutput("rst_paddr", PADDR, 8'h00);
      checkOutput("rst_pwdata", PWDATA, 32'h0);
      checkOutput("rst_pwrite", PWRITE, 1'b0);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] zero-wait write");
      slave_wait = 0;
      applyStimulus(1'b1, 1'b0, 8'h04, 32'h0000_00A5, 32'h0);
      checkOutput("wr_setup_psel", PSEL, 1'b1);
      checkOutput("wr_setup_penable", PENABLE, 1'b0);
      checkOutput("wr_setup_paddr", PADDR, 8'h04);
      checkOutput("wr_setup_pwrite", PWRITE, 1'b1);
      checkOutput("wr_setup_pwdata", PWDATA, 32'h0000_00A5);
      checkOutput("wr_setup_cmd_ready", cmd_ready, 1'b0);
      @(negedge clk);
      checkOutput("wr_access_psel", PSEL, 1'b1);
      checkOutput("wr_access_penable", PENABLE, 1'b1);
      checkOutput("wr_access_rsp_valid", rsp_valid, 1'b0);
      @(negedge clk);
      checkOutput("wr_rsp_valid_t3", rsp_valid, 1'b1);
      checkOutput("wr_rsp_error", rsp_error, 1'b0);
      checkOutput("wr_rsp_rdata", rsp_rdata, 32'h0);
      checkOutput("wr_bus_released", {PSEL, PENABLE}, 2'b00);
      finishResp("wr");

      $display("[TB] read with three wait states");
      slave_wait = 3;
      match_at   = 1;
      match_data = 32'hDEAD_BEEF;
      applyStimulus(1'b0, 1'b0, 8'h08, 32'h1234_5678, 32'h0);
      checkOutput("rd_pwrite", PWRITE, 1'b0);
      checkOutput("rd_pwdata_zero", PWDATA, 32'h0);
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (PSEL !== 1'b1 || PADDR !== 8'h08 || PENABLE !== (i > 0) || rsp_valid !== 1'b0) ok = 1'b0;
         @(negedge clk);
      end
      checkOutput("rd_bus_stable", ok, 1'b1);
      checkOutput("rd_rsp_valid_t6", rsp_valid, 1'b1);
      checkOutput("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      checkOutput("rd_rsp_error", rsp_error, 1'b0);
      finishResp("rd");

      $display("[TB] poll matching on third read");
      slave_wait = 0;
      match_at   = 3;
      miss_data  = 32'h0000_0002;
      match_data = 32'h0000_0003;
      applyStimulus(1'b0, 1'b1, 8'h00, 32'h0000_0001, 32'h0000_0001);
      waitResp(n);
      checkOutput("poll_latency", n, 15);
      checkOutput("poll_setups", setup_cnt, 3);
      checkOutput("poll_accesses", access_cnt, 3);
      checkOutput("poll_gap_min", gap_min, 4);
      checkOutput("poll_gap_max", gap_max, 4);
      checkOutput("poll_rsp_error", rsp_error, 1'b0);
      checkOutput("poll_rsp_rdata", rsp_rdata, 32'h0000_0003);
      finishResp("poll");

      $display("[TB] poll exhausting the read budget");
      match_at = 100;
      applyStimulus(1'b0, 1'b1, 8'h00, 32'h0000_0001, 32'h0000_0001);
      waitResp(n);
      checkOutput("pollx_latency", n, 15);
      checkOutput("pollx_accesses", access_cnt, 3);
      checkOutput("pollx_rsp_error", rsp_error, 1'b1);
      checkOutput("pollx_rsp_rdata", rsp_rdata, 32'h0000_0002);
      finishResp("pollx");

      $display("[TB] poll with zero mask");
      applyStimulus(1'b0, 1'b1, 8'h00, 32'h0000_00FF, 32'h0);
      waitResp(n);
      checkOutput("pollm_latency", n, 3);
      checkOutput("pollm_accesses", access_cnt, 1);
      checkOutput("pollm_rsp_error", rsp_error, 1'b0);
      checkOutput("pollm_rsp_rdata", rsp_rdata, 32'h0000_0002);
      finishResp("pollm");

      $display("[TB] poll flag on a write");
      applyStimulus(1'b1, 1'b1, 8'h18, 32'h0000_0055, 32'hFFFF_FFFF);
      checkOutput("pollw_pwrite", PWRITE, 1'b1);
      checkOutput("pollw_pwdata", PWDATA, 32'h0000_0055);
      waitResp(n);
      checkOutput("pollw_latency", n, 3);
      checkOutput("pollw_accesses", access_cnt, 1);
      checkOutput("pollw_rsp_rdata", rsp_rdata, 32'h0);
      finishResp("pollw");

      $display("[TB] PREADY stuck low");
      slave_wait = -1;
      applyStimulus(1'b0, 1'b0, 8'h0C, 32'h0, 32'h0);
      waitResp(n);
      checkOutput("to_latency", n, 18);
      checkOutput("to_accesses", access_cnt, 16);
      checkOutput("to_rsp_error", rsp_error, 1'b1);
      checkOutput("to_bus_released", {PSEL, PENABLE}, 2'b00);
      finishResp("to");
      slave_wait = 0;
      applyStimulus(1'b1, 1'b0, 8'h10, 32'h0000_00F0, 32'h0);
      waitResp(n);
      checkOutput("after_to_latency", n, 3);
      checkOutput("after_to_rsp_error", rsp_error, 1'b0);
      finishResp("after_to");

      $display("[TB] response backpressure");
      match_at   = 1;
      match_data = 32'h1234_5678;
      applyStimulus(1'b0, 1'b0, 8'h14, 32'h0, 32'h0);
      waitResp(n);
      checkOutput("bp_latency", n, 3);
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_error !== 1'b0 || cmd_ready !== 1'b0)
            ok = 1'b0;
         @(negedge clk);
      end
      checkOutput("bp_rsp_stable", ok, 1'b1);
      finishResp("bp");

      $display("[TB] reset during ACCESS");
      slave_wait = -1;
      applyStimulus(1'b0, 1'b0, 8'h20, 32'h0, 32'h0);
      @(negedge clk);
      checkOutput("rsta_in_access", {PSEL, PENABLE}, 2'b11);
      reset = 1'b1;
      #1;
      checkOutput("rsta_bus_dropped", {PSEL, PENABLE}, 2'b00);
      @(negedge clk);
      reset = 1'b0;
      slave_wait = 0;
      ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (rsp_valid !== 1'b0) ok = 1'b0;
         @(negedge clk);
      end
      checkOutput("rsta_no_rsp", ok, 1'b1);
      checkOutput("rsta_cmd_ready", cmd_ready, 1'b1);
      applyStimulus(1'b1, 1'b0, 8'h04, 32'h0000_0001, 32'h0);
      waitResp(n);
      checkOutput("rsta_next_latency", n, 3);
      finishResp("rsta_next");

      #1;
      checkOutput("apb_protocol", proto_viol, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
